// File: rtl/sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// sync_pulse_gen
// Transmit side of the auto-sync handshake, clocked in the bus domain.
// Primary role: drives one active-low sync pulse on the shared line, actively
// drives it high for a while, then releases it.
// Secondary role: waits for a complete low pulse from the primary, then
// reflects one pulse back after a programmable delay, or gives up with a
// timeout if no complete pulse arrives.
//
// Ports
//   clock_bus   in   sole clock
//   reset_bus   in   asynchronous active-high reset
//   as_en       in   rising edge starts a sequence, low aborts it
//   as_prim     in   1 = primary role, 0 = secondary role (sampled at start)
//   as_delay    in   secondary reflect delay in cycles (latched at start)
//   sync_in     in   sync line, already synchronized to clock_bus
//   sync_out    out  line drive value (idles 1)
//   sync_oe     out  line output enable
//   as_active   out  high while a sequence is running
//   as_done     out  one-cycle pulse at normal sequence end
//   as_timeout  out  secondary saw no complete pulse, held until next start
// -----------------------------------------------------------------------------
module sync_pulse_gen #(
   parameter int PULSE_LENGTH = 3,
   parameter int PULSE_WAIT   = 5,
   parameter int TIME_BITS    = 8,
   parameter int DELAY_BITS   = 12
) (
   input  logic                  clock_bus,
   input  logic                  reset_bus,
   input  logic                  as_en,
   input  logic                  as_prim,
   input  logic [DELAY_BITS-1:0] as_delay,
   input  logic                  sync_in,
   output logic                  sync_out,
   output logic                  sync_oe,
   output logic                  as_active,
   output logic                  as_done,
   output logic                  as_timeout
);

   // One phase counter is shared by the pulse, hold and delay phases, so it
   // must be wide enough for the largest of them.
   localparam int LEN_MAX = (PULSE_LENGTH > PULSE_WAIT) ? PULSE_LENGTH : PULSE_WAIT;
   localparam int LEN_W   = $clog2(LEN_MAX + 1);
   localparam int CNT_W   = (LEN_W > DELAY_BITS) ? LEN_W : DELAY_BITS;

   localparam logic [CNT_W-1:0]     PULSE_LAST = CNT_W'(PULSE_LENGTH - 1);
   localparam logic [CNT_W-1:0]     WAIT_LAST  = CNT_W'(PULSE_WAIT - 1);
   localparam logic [TIME_BITS-1:0] TIME_MAX   = {TIME_BITS{1'b1}};

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      PRIM_PULSE    = 3'd1,
      SEC_WAIT_FALL = 3'd2,
      SEC_WAIT_RISE = 3'd3,
      SEC_DELAY     = 3'd4,
      SEC_PULSE     = 3'd5,
      HOLD          = 3'd6,
      DONE          = 3'd7
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TIME_BITS-1:0]    timer_q, timer_d;
   logic [DELAY_BITS-1:0]   delay_q, delay_d;
   logic                    as_en_ff_q;
   logic                    sync_in_ff_q;
   logic                    sync_out_q, sync_out_d;
   logic                    sync_oe_q, sync_oe_d;
   logic                    as_active_q, as_active_d;
   logic                    as_done_q, as_done_d;
   logic                    as_timeout_q, as_timeout_d;

   logic                    start_s;
   logic                    fall_s;
   logic                    rise_s;
   logic [DELAY_BITS-1:0]   delay_m1_s;
   logic                    delay_last_s;

   // Edge detection and delay terminal count.
   always_comb begin
      start_s      = as_en & ~as_en_ff_q;
      fall_s       = sync_in_ff_q & ~sync_in;
      rise_s       = ~sync_in_ff_q & sync_in;
      delay_m1_s   = delay_q - DELAY_BITS'(1);
      delay_last_s = (cnt_q == CNT_W'(delay_m1_s));
   end

   // Next-state, counter and status computation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      timer_d      = timer_q;
      delay_d      = delay_q;
      as_timeout_d = as_timeout_q;

      if ((state_q != IDLE) && !as_en) begin
         // Abort: release the line, no done pulse, timeout flag untouched.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // The role only selects the first state, so the state itself
               // carries the latched role for the rest of the sequence.
               if (start_s) begin
                  delay_d      = as_delay;
                  timer_d      = {TIME_BITS{1'b0}};
                  as_timeout_d = 1'b0;
                  state_d      = as_prim ? PRIM_PULSE : SEC_WAIT_FALL;
               end else begin
                  state_d = IDLE;
               end
            end
            PRIM_PULSE, SEC_PULSE: begin
               if (cnt_q == PULSE_LAST) begin
                  state_d = HOLD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SEC_WAIT_FALL: begin
               // Timeout wins over an edge seen in the same cycle.
               if (timer_q == TIME_MAX) begin
                  as_timeout_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  timer_d = timer_q + TIME_BITS'(1);
                  if (fall_s) begin
                     state_d = SEC_WAIT_RISE;
                  end else begin
                     state_d = SEC_WAIT_FALL;
                  end
               end
            end
            SEC_WAIT_RISE: begin
               if (timer_q == TIME_MAX) begin
                  as_timeout_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  timer_d = timer_q + TIME_BITS'(1);
                  if (rise_s) begin
                     // Zero delay drives low on the same edge the rise is seen.
                     state_d = (delay_q == {DELAY_BITS{1'b0}}) ? SEC_PULSE : SEC_DELAY;
                  end else begin
                     state_d = SEC_WAIT_RISE;
                  end
               end
            end
            SEC_DELAY: begin
               // Entered on the rise edge, so delay-1 further counts reach
               // the pulse exactly delay edges after the rise.
               if (delay_last_s) begin
                  state_d = SEC_PULSE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt_q == WAIT_LAST) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (state_d != state_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_d;
      end
   end

   // Output values are decoded from the next state so they are registered
   // and change on the same edge as the state.
   always_comb begin
      sync_out_d  = !((state_d == PRIM_PULSE) || (state_d == SEC_PULSE));
      sync_oe_d   = (state_d == PRIM_PULSE) || (state_d == SEC_PULSE) || (state_d == HOLD);
      as_active_d = !((state_d == IDLE) || (state_d == DONE));
      as_done_d   = (state_d == DONE);
   end

   // State, counters, edge-detect history and registered outputs.
   always_ff @(posedge clock_bus or posedge reset_bus) begin
      if (reset_bus) begin
         state_q      <= IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         timer_q      <= {TIME_BITS{1'b0}};
         delay_q      <= {DELAY_BITS{1'b0}};
         as_en_ff_q   <= 1'b0;
         sync_in_ff_q <= 1'b1;
         sync_out_q   <= 1'b1;
         sync_oe_q    <= 1'b0;
         as_active_q  <= 1'b0;
         as_done_q    <= 1'b0;
         as_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         delay_q      <= delay_d;
         as_en_ff_q   <= as_en;
         sync_in_ff_q <= sync_in;
         sync_out_q   <= sync_out_d;
         sync_oe_q    <= sync_oe_d;
         as_active_q  <= as_active_d;
         as_done_q    <= as_done_d;
         as_timeout_q <= as_timeout_d;
      end
   end

   assign sync_out   = sync_out_q;
   assign sync_oe    = sync_oe_q;
   assign as_active  = as_active_q;
   assign as_done    = as_done_q;
   assign as_timeout = as_timeout_q;

endmodule

// File: tb/tb_sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_sync_pulse_gen
// Self-checking bench for sync_pulse_gen with default parameters
// (PULSE_LENGTH=3, PULSE_WAIT=5, TIME_BITS=8, DELAY_BITS=12).
// Each scenario row gives the stimulus timing and the hand-derived edges at
// which the pulse starts, ends and the sequence completes. Cycle c's inputs
// are applied at the falling edge before rising edge c; the outputs expected
// after edge c are queued when the inputs are driven and popped after the edge.
// -----------------------------------------------------------------------------
module tb_sync_pulse_gen;

   logic        clock_bus = 1'b0;
   logic        reset_bus;
   logic        as_en;
   logic        as_prim;
   logic [11:0] as_delay;
   logic        sync_in;
   logic        sync_out;
   logic        sync_oe;
   logic        as_active;
   logic        as_done;
   logic        as_timeout;

   always #5 clock_bus = ~clock_bus;

   sync_pulse_gen dut (
      .clock_bus  (clock_bus),
      .reset_bus  (reset_bus),
      .as_en      (as_en),
      .as_prim    (as_prim),
      .as_delay   (as_delay),
      .sync_in    (sync_in),
      .sync_out   (sync_out),
      .sync_oe    (sync_oe),
      .as_active  (as_active),
      .as_done    (as_done),
      .as_timeout (as_timeout)
   );

   // Scenario: start at edge 1; sync_in low for cycles [fall_cyc, rise_cyc);
   // sync_out low for edges [low_edge, high_edge); done pulse at done_edge.
   typedef struct {
      logic        prim;
      logic [11:0] delay;
      int          fall_cyc;
      int          rise_cyc;
      int          low_edge;
      int          high_edge;
      int          done_edge;
      logic        exp_to;
   } vec_t;

   // Expected vector bits: {sync_out, sync_oe, as_active, as_done, as_timeout}
   typedef struct {
      logic [4:0] v;
      string      tag;
   } exp_t;

   localparam logic [4:0] IDLE_OUT = 5'b10000;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_to  = 1'b0;
   vec_t vecs[11];

   task automatic check_out(input int edge_no);
      exp_t       e;
      logic [4:0] got;
      got = {sync_out, sync_oe, as_active, as_done, as_timeout};
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty edge %0d: got %b, no expected entry", edge_no, got);
      end else begin
         e = sb_q.pop_front();
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s edge %0d: out/oe/active/done/timeout got %b expected %b",
                     e.tag, edge_no, got, e.v);
         end
      end
   endtask

   task automatic cycle(input logic en, input logic prim, input logic [11:0] dly,
                        input logic sin, input logic [4:0] exp_v, input string tag,
                        input int edge_no);
      exp_t e;
      @(negedge clock_bus);
      as_en    = en;
      as_prim  = prim;
      as_delay = dly;
      sync_in  = sin;
      e.v      = exp_v;
      e.tag    = tag;
      sb_q.push_back(e);
      @(posedge clock_bus);
      #1;
      check_out(edge_no);
   endtask

   // Runs one scenario row; last_cyc < 0 runs it to completion.
   task automatic run_row(input vec_t r, input int idx, input int last_cyc);
      int         total;
      logic       en, sin;
      logic [4:0] ex;
      string      tag;
      total = (last_cyc < 0) ? (r.done_edge + 3) : (last_cyc + 1);
      tag   = $sformatf("row%0d", idx);
      for (int c = 0; c < total; c++) begin
         en    = (c >= 1) && (c <= r.done_edge);
         sin   = !((c >= r.fall_cyc) && (c < r.rise_cyc));
         ex[4] = !((c >= r.low_edge) && (c < r.high_edge));
         ex[3] = (r.low_edge >= 0) && (c >= r.low_edge) && (c < r.done_edge);
         ex[2] = (c >= 1) && (c < r.done_edge);
         ex[1] = (c == r.done_edge);
         ex[0] = (c < 1) ? prev_to : (r.exp_to && (c >= r.done_edge));
         cycle(en, r.prim, r.delay, sin, ex, tag, c);
      end
      if (last_cyc < 0) begin
         prev_to = r.exp_to;
      end else begin
         prev_to = prev_to;
      end
   endtask

   initial begin
      exp_t e;

      //          prim  delay   fall  rise   low  high done  to
      vecs[0]  = '{1'b1, 12'd0, -1,   -1,     1,   4,   9,  1'b0}; // primary
      vecs[1]  = '{1'b0, 12'd4,  3,    6,    10,  13,  18,  1'b0}; // secondary D=4
      vecs[2]  = '{1'b0, 12'd0,  3,    5,     5,   8,  13,  1'b0}; // secondary D=0
      vecs[3]  = '{1'b0, 12'd1,  2,    4,     5,   8,  13,  1'b0}; // secondary D=1
      vecs[4]  = '{1'b0, 12'd7, 20,   40,    47,  50,  55,  1'b0}; // secondary D=7
      vecs[5]  = '{1'b1, 12'd9, -1,   -1,     1,   4,   9,  1'b0}; // primary ignores delay
      vecs[6]  = '{1'b0, 12'd3, -1,   -1,    -1,  -1, 257,  1'b1}; // no activity
      vecs[7]  = '{1'b0, 12'd2, 10, 10000,   -1,  -1, 257,  1'b1}; // fall, no rise
      vecs[8]  = '{1'b1, 12'd0, -1,   -1,     1,   4,   9,  1'b0}; // clears timeout
      vecs[9]  = '{1'b0, 12'd0, 50,  257,    -1,  -1, 257,  1'b1}; // rise vs timeout
      vecs[10] = '{1'b1, 12'd0, -1,   -1,     1,   4,   9,  1'b0}; // clears timeout

      // Reset state, before any clock edge and across an edge.
      reset_bus = 1'b1;
      as_en     = 1'b0;
      as_prim   = 1'b0;
      as_delay  = 12'd0;
      sync_in   = 1'b1;
      #2;
      e.v   = IDLE_OUT;
      e.tag = "reset_async";
      sb_q.push_back(e);
      check_out(-1);
      cycle(1'b0, 1'b0, 12'd0, 1'b1, IDLE_OUT, "reset_held", 0);
      @(negedge clock_bus);
      reset_bus = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_row(vecs[i], i, -1);
      end

      // Abort: primary, as_en dropped during the second low cycle.
      for (int c = 0; c < 13; c++) begin
         cycle((c == 1) || (c == 2), 1'b1, 12'd0, 1'b1,
               ((c == 1) || (c == 2)) ? 5'b01100 : IDLE_OUT, "abort", c);
      end

      // Reset between edges while the secondary drives its pulse.
      run_row(vecs[2], 2, 5);
      #2;
      reset_bus = 1'b1;
      #1;
      e.v   = IDLE_OUT;
      e.tag = "reset_mid_pulse";
      sb_q.push_back(e);
      check_out(-1);
      @(negedge clock_bus);
      as_en   = 1'b0;
      sync_in = 1'b1;
      reset_bus = 1'b0;
      prev_to = 1'b0;
      run_row(vecs[0], 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
